// File: rtl/program_loader.sv
// Byte-link command controller: halts the CPU, drives its external memory port for WRITE/READ,
// and handles RUN/HALT. Define LOADER_CHECKSUM_EN to append a checksum byte to WRITE.
module program_loader #(
  parameter bit         RESET_PAUSED    = 1'b1,
  parameter logic [2:0] WORD_WRITE_MODE = 3'd3,
  parameter logic [2:0] WORD_READ_MODE  = 3'd3,
  parameter logic [2:0] NO_ACCESS_MODE  = 3'd0,
  parameter int         READ_LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rxData,
  input  logic        rxValid,
  output logic        rxReady,
  output logic [7:0]  txData,
  output logic        txValid,
  input  logic        txReady,
  output logic        pause,
  output logic        externalMemoryControl,
  output logic [31:0] externalAddress,
  output logic [31:0] externalData,
  output logic [2:0]  externalReadMode,
  output logic [2:0]  externalWriteMode,
  input  logic [31:0] externalDataOut,
  output logic        busy,
  output logic        error
);
  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] NAK = 8'hEE;
  localparam logic [1:0] LAT = 2'(READ_LATENCY);

  typedef enum logic [3:0] {
    IDLE, GET_ADDR, GET_COUNT, GET_DATA, DO_WRITE,
`ifdef LOADER_CHECKSUM_EN
    GET_CSUM,
`endif
    DO_READ, SEND_RD, SEND_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d, lat_q, lat_d;
  logic        is_wr_q, is_wr_d, pause_save_q, pause_save_d;
  logic [15:0] count_q, count_d;
  logic [31:0] rd_q, rd_d, addr_q, addr_d, data_q, data_d;
  logic [7:0]  csum_q, csum_d, tx_data_q, tx_data_d;
  logic        rx_ready_q, rx_ready_d, tx_valid_q, tx_valid_d;
  logic        pause_q, pause_d, emc_q, emc_d, busy_q, busy_d, error_q, error_d;
  logic [2:0]  rmode_q, rmode_d, wmode_q, wmode_d;
  logic        rx_acc, tx_acc, wr_done;

  assign rx_acc = rxValid & rx_ready_q;
  assign tx_acc = tx_valid_q & txReady;

  always_comb begin
    state_d = state_q;  idx_d = idx_q;  lat_d = lat_q;  is_wr_d = is_wr_q;
    pause_save_d = pause_save_q;  count_d = count_q;  rd_d = rd_q;
    addr_d = addr_q;  data_d = data_q;  csum_d = csum_q;  tx_data_d = tx_data_q;
    pause_d = pause_q;  emc_d = emc_q;  error_d = error_q;
    rmode_d = NO_ACCESS_MODE;  wmode_d = NO_ACCESS_MODE;  wr_done = 1'b0;
    case (state_q)
      IDLE: if (rx_acc) begin
        idx_d  = 2'd0;
        csum_d = 8'd0;
        case (rxData)
          8'h01, 8'h02: begin
            is_wr_d      = (rxData == 8'h01);
            pause_save_d = pause_q;
            pause_d      = 1'b1;
            emc_d        = 1'b1;
            state_d      = GET_ADDR;
          end
          8'h03: begin pause_d = 1'b0; tx_data_d = ACK; state_d = SEND_RESP; end
          8'h04: begin pause_d = 1'b1; error_d = 1'b0; tx_data_d = ACK; state_d = SEND_RESP; end
          default: begin error_d = 1'b1; tx_data_d = NAK; state_d = SEND_RESP; end
        endcase
      end
      GET_ADDR: if (rx_acc) begin
        addr_d = {addr_q[23:0], rxData};
        csum_d = csum_q + rxData;
        idx_d  = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          if (is_wr_q) state_d = GET_COUNT;
          else begin
            state_d = DO_READ;
            lat_d   = 2'd0;
            rmode_d = WORD_READ_MODE;
          end
        end
      end
      GET_COUNT: if (rx_acc) begin
        count_d = {count_q[7:0], rxData};
        csum_d  = csum_q + rxData;
        idx_d   = idx_q + 2'd1;
        if (idx_q == 2'd1) begin
          idx_d = 2'd0;
          if ({count_q[7:0], rxData} == 16'd0) wr_done = 1'b1;
          else state_d = GET_DATA;
        end
      end
      GET_DATA: if (rx_acc) begin
        data_d = {data_q[23:0], rxData};
        csum_d = csum_q + rxData;
        idx_d  = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = DO_WRITE;
          wmode_d = WORD_WRITE_MODE;
        end
      end
      DO_WRITE: begin
        addr_d  = addr_q + 32'd4;  // natural 32-bit wrap: FFFFFFFC -> 0
        count_d = count_q - 16'd1;
        if (count_q == 16'd1) wr_done = 1'b1;
        else state_d = GET_DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      GET_CSUM: if (rx_acc) begin
        state_d = SEND_RESP;
        if (rxData == csum_q) tx_data_d = ACK;
        else begin error_d = 1'b1; tx_data_d = NAK; end
      end
`endif
      // readMode is held for LAT cycles; the word is sampled one cycle after it drops
      DO_READ: begin
        if (lat_q == LAT) begin
          rd_d      = externalDataOut;
          tx_data_d = externalDataOut[31:24];
          idx_d     = 2'd0;
          state_d   = SEND_RD;
        end else begin
          lat_d = lat_q + 2'd1;
          if (lat_q + 2'd1 != LAT) rmode_d = WORD_READ_MODE;
        end
      end
      SEND_RD: if (tx_acc) begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = IDLE;
          pause_d = pause_save_q;
          emc_d   = 1'b0;
        end else begin
          tx_data_d = rd_q[23:16];
          rd_d      = {rd_q[23:0], 8'h00};
        end
      end
      SEND_RESP: if (tx_acc) begin
        state_d = IDLE;
        if (emc_q) begin
          pause_d = pause_save_q;
          emc_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (wr_done) begin
`ifdef LOADER_CHECKSUM_EN
      state_d = GET_CSUM;
`else
      state_d   = SEND_RESP;
      tx_data_d = ACK;
`endif
    end
    rx_ready_d = (state_d == IDLE) || (state_d == GET_ADDR) || (state_d == GET_COUNT) ||
`ifdef LOADER_CHECKSUM_EN
                 (state_d == GET_CSUM) ||
`endif
                 (state_d == GET_DATA);
    tx_valid_d = (state_d == SEND_RD) || (state_d == SEND_RESP);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;  idx_q <= '0;  lat_q <= '0;  is_wr_q <= 1'b0;
      pause_save_q <= RESET_PAUSED;  count_q <= '0;  rd_q <= '0;
      addr_q <= '0;  data_q <= '0;  csum_q <= '0;  tx_data_q <= '0;
      rx_ready_q <= 1'b1;  tx_valid_q <= 1'b0;  pause_q <= RESET_PAUSED;
      emc_q <= 1'b0;  busy_q <= 1'b0;  error_q <= 1'b0;
      rmode_q <= NO_ACCESS_MODE;  wmode_q <= NO_ACCESS_MODE;
    end else begin
      state_q <= state_d;  idx_q <= idx_d;  lat_q <= lat_d;  is_wr_q <= is_wr_d;
      pause_save_q <= pause_save_d;  count_q <= count_d;  rd_q <= rd_d;
      addr_q <= addr_d;  data_q <= data_d;  csum_q <= csum_d;  tx_data_q <= tx_data_d;
      rx_ready_q <= rx_ready_d;  tx_valid_q <= tx_valid_d;  pause_q <= pause_d;
      emc_q <= emc_d;  busy_q <= busy_d;  error_q <= error_d;
      rmode_q <= rmode_d;  wmode_q <= wmode_d;
    end
  end

  assign rxReady               = rx_ready_q;
  assign txData                = tx_data_q;
  assign txValid               = tx_valid_q;
  assign pause                 = pause_q;
  assign externalMemoryControl = emc_q;
  assign externalAddress       = addr_q;
  assign externalData          = data_q;
  assign externalReadMode      = rmode_q;
  assign externalWriteMode     = wmode_q;
  assign busy                  = busy_q;
  assign error                 = error_q;
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a command-level model predicts writes and tx bytes,
// a per-cycle monitor compares the DUT against it, and literal checks pin key results.
module tb_program_loader;
  typedef logic [7:0] u8;

  logic        clk = 1'b0, rst;
  logic [7:0]  rxData, txData;
  logic        rxValid, rxReady, txValid, txReady;
  logic        pause, emc, busy, error;
  logic [31:0] ext_addr, ext_data;
  logic [2:0]  rmode, wmode;
  logic [31:0] ext_dout = '0;
  logic [31:0] smem [256] = '{default: 32'h0};

  always #5 clk = ~clk;

  program_loader dut (
    .clk(clk), .rst(rst), .rxData(rxData), .rxValid(rxValid), .rxReady(rxReady),
    .txData(txData), .txValid(txValid), .txReady(txReady), .pause(pause),
    .externalMemoryControl(emc), .externalAddress(ext_addr), .externalData(ext_data),
    .externalReadMode(rmode), .externalWriteMode(wmode), .externalDataOut(ext_dout),
    .busy(busy), .error(error)
  );

  // processor memory: word-indexed by addr[9:2], registered read
  always @(posedge clk) begin
    if (wmode == 3'd3) smem[ext_addr[9:2]] <= ext_data;
    if (rmode == 3'd3) ext_dout <= smem[ext_addr[9:2]];
  end

  int errors = 0, checks = 0;
  bit [31:0] mmem [bit [31:0]];
  bit m_pause, m_error, done;
  u8 exp_tx[$], got_tx[$];
  logic [31:0] exp_wa[$], exp_wd[$];
  int hs_cnt, stall_at, stall_left;
  logic prev_v, prev_r;
  logic [7:0] prev_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic u8 csum(input u8 q[$]);
    u8 s = 8'h00;
    for (int k = 1; k < q.size(); k++) s += q[k];
    return s;
  endfunction

  // command-level model: what a command must do to memory, the byte link and the flags
  task automatic model_cmd(input u8 q[$]);
    logic [31:0] a, w;
    int n;
    case (q[0])
      8'h01: begin
        a = {q[1], q[2], q[3], q[4]};
        n = {q[5], q[6]};
        for (int i = 0; i < n; i++) begin
          w = {q[7+4*i], q[8+4*i], q[9+4*i], q[10+4*i]};
          exp_wa.push_back(a); exp_wd.push_back(w);
          mmem[a] = w;
          a = a + 32'd4;
        end
`ifdef LOADER_CHECKSUM_EN
        begin
          u8 s = 8'h00;
          for (int k = 1; k < 7 + 4*n; k++) s += q[k];
          if (q[7+4*n] == s) exp_tx.push_back(8'hA5);
          else begin exp_tx.push_back(8'hEE); m_error = 1'b1; end
        end
`else
        exp_tx.push_back(8'hA5);
`endif
      end
      8'h02: begin
        a = {q[1], q[2], q[3], q[4]};
        w = mmem.exists(a) ? mmem[a] : 32'h0;
        exp_tx.push_back(w[31:24]); exp_tx.push_back(w[23:16]);
        exp_tx.push_back(w[15:8]);  exp_tx.push_back(w[7:0]);
      end
      8'h03: begin m_pause = 1'b0; exp_tx.push_back(8'hA5); end
      8'h04: begin m_pause = 1'b1; m_error = 1'b0; exp_tx.push_back(8'hA5); end
      default: begin m_error = 1'b1; exp_tx.push_back(8'hEE); end
    endcase
  endtask

  task automatic send_byte(input u8 b);
    int n = 0;
    rxData = b; rxValid = 1'b1;
    while (!rxReady && n < 200) begin @(negedge clk); n++; end
    if (n == 200) chk("rx_timeout", {31'h0, rxReady}, 32'h1);
    else @(negedge clk);
    rxValid = 1'b0;
  endtask

  task automatic run_cmd(input u8 q[$]);
    int n = 0;
    model_cmd(q);
    got_tx.delete();
    foreach (q[i]) send_byte(q[i]);
    while ((busy || exp_tx.size() != 0 || exp_wa.size() != 0) && n < 500) begin
      @(negedge clk); n++;
    end
    if (n == 500) chk("cmd_timeout", {31'h0, busy}, 32'h0);
    chk("idle_pause", {31'h0, pause}, {31'h0, m_pause});
    chk("idle_error", {31'h0, error}, {31'h0, m_error});
    chk("idle_emc", {31'h0, emc}, 32'h0);
  endtask

  task automatic monitor();
    while (!done) begin
      @(negedge clk);
      if (stall_left > 0) begin txReady = 1'b0; stall_left--; end
      else txReady = 1'b1;
      if (rst) begin prev_v = 1'b0; continue; end
      if (txValid) chk("rx_ready_in_send", {31'h0, rxReady}, 32'h0);
      if (wmode !== 3'd0) begin
        chk("wmode_code", {29'h0, wmode}, 32'h3);
        chk("wr_rx_ready", {31'h0, rxReady}, 32'h0);
        chk("wr_pause_emc", {30'h0, pause, emc}, 32'h3);
        if (exp_wa.size() == 0) chk("unexpected_write", ext_addr, 32'hxxxxxxxx);
        else begin
          chk("wr_addr", ext_addr, exp_wa.pop_front());
          chk("wr_data", ext_data, exp_wd.pop_front());
        end
      end
      if (rmode !== 3'd0) begin
        chk("rmode_code", {29'h0, rmode}, 32'h3);
        chk("rd_pause_emc", {30'h0, pause, emc}, 32'h3);
      end
      if (prev_v && !prev_r) begin
        chk("tx_hold_valid", {31'h0, txValid}, 32'h1);
        chk("tx_hold_data", {24'h0, txData}, {24'h0, prev_d});
      end
      if (txValid && txReady) begin
        got_tx.push_back(txData);
        if (exp_tx.size() == 0) chk("unexpected_tx", {24'h0, txData}, 32'hxxxxxxxx);
        else chk("tx_byte", {24'h0, txData}, {24'h0, exp_tx.pop_front()});
        hs_cnt++;
        if (hs_cnt == stall_at) stall_left = 5;
      end
      prev_v = txValid; prev_r = txReady; prev_d = txData;
    end
  endtask

  task automatic main_seq();
    u8 q[$];
    // WRITE two words at 0x10
    q = {8'h01, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h02,
         8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
`ifdef LOADER_CHECKSUM_EN
    q.push_back(csum(q));
`endif
    run_cmd(q);
    chk("write_ack", {24'h0, got_tx[0]}, 32'hA5);
    chk("mem_10", smem[4], 32'hDEADBEEF);
    chk("mem_14", smem[5], 32'h01234567);

    // READ 0x14 with a 5-cycle sink stall after the second byte
    stall_at = hs_cnt + 2;
    run_cmd('{8'h02, 8'h00, 8'h00, 8'h00, 8'h14});
    chk("read_14", {got_tx[0], got_tx[1], got_tx[2], got_tx[3]}, 32'h01234567);

    // RUN, read while running (pause forced then restored), HALT
    run_cmd('{8'h03});
    chk("run_pause", {31'h0, pause}, 32'h0);
    run_cmd('{8'h02, 8'h00, 8'h00, 8'h00, 8'h10});
    chk("read_10", {got_tx[0], got_tx[1], got_tx[2], got_tx[3]}, 32'hDEADBEEF);
    chk("pause_restored", {31'h0, pause}, 32'h0);
    run_cmd('{8'h04});
    chk("halt_pause", {31'h0, pause}, 32'h1);

    // bad opcode then HALT clears error
    run_cmd('{8'h7F});
    chk("nak", {24'h0, got_tx[0]}, 32'hEE);
    chk("err_set", {31'h0, error}, 32'h1);
    run_cmd('{8'h04});
    chk("err_clr", {31'h0, error}, 32'h0);

    // address wrap FFFFFFFC -> 0
    q = {8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFC, 8'h00, 8'h02,
         8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'h55, 8'h55, 8'h55, 8'h55};
`ifdef LOADER_CHECKSUM_EN
    q.push_back(csum(q));
`endif
    run_cmd(q);
    chk("mem_fffffffc", smem[255], 32'hAAAAAAAA);
    chk("mem_wrap_0", smem[0], 32'h55555555);

    // count = 0
    q = {8'h01, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    q.push_back(csum(q));
`endif
    run_cmd(q);
    chk("count0_ack", {24'h0, got_tx[0]}, 32'hA5);

`ifdef LOADER_CHECKSUM_EN
    q = {8'h01, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h02,
         8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    q.push_back(csum(q) + 8'h01);
    run_cmd(q);
    chk("csum_nak", {24'h0, got_tx[0]}, 32'hEE);
    chk("csum_err", {31'h0, error}, 32'h1);
    chk("csum_mem_40", smem[16], 32'h11223344);
    chk("csum_mem_44", smem[17], 32'h55667788);
    run_cmd('{8'h04});
`endif

    // reset in the middle of a WRITE drops it
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_pause = 1'b1; m_error = 1'b0;
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_rxready", {31'h0, rxReady}, 32'h1);
    chk("midrst_pause", {31'h0, pause}, 32'h1);
    run_cmd('{8'h02, 8'h00, 8'h00, 8'h00, 8'h14});
    chk("read_after_rst", {got_tx[0], got_tx[1], got_tx[2], got_tx[3]}, 32'h01234567);
  endtask

  initial begin
    rst = 1'b1; rxValid = 1'b0; rxData = 8'h00; txReady = 1'b1;
    m_pause = 1'b1; m_error = 1'b0; done = 1'b0;
    hs_cnt = 0; stall_at = -1; stall_left = 0;
    prev_v = 1'b0; prev_r = 1'b1; prev_d = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_pause", {31'h0, pause}, 32'h1);
    chk("rst_emc", {31'h0, emc}, 32'h0);
    chk("rst_rxready", {31'h0, rxReady}, 32'h1);
    chk("rst_txvalid", {31'h0, txValid}, 32'h0);
    chk("rst_error", {31'h0, error}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_modes", {26'h0, rmode, wmode}, 32'h0);
    chk("rst_txdata", {24'h0, txData}, 32'h0);
    rst = 1'b0;
    fork
      monitor();
      begin main_seq(); done = 1'b1; end
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
